ternary_neuron_acc: RTL

TERNARY_NEURON_ACC -- requirements
Module: ternary_neuron_acc

---
 rtl/ternary_neuron_acc.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ternary_neuron_acc.sv
// ternary_neuron_acc: accumulates signed (pos_cnt - neg_cnt) chunk beats of one
//   ternary-weight neuron, then holds the pre-activation sum and the threshold
//   activation until the consumer takes it.
// Ports: clk/rst (async active-high); in_valid/in_ready + pos_cnt/neg_cnt/in_last
//   form the beat input; out_valid/out_ready + out_sum/out_act/out_err form the
//   result output.
// Latency: out_valid rises 1 clock after the accepted last beat. in_ready is low
//   while a result is held, including the cycle it is taken.
// Build option: define ACC_SAT_EN to saturate the accumulator; otherwise it wraps.
module ternary_neuron_acc #(
  parameter int                        ACC_W     = 10,
  parameter int                        MAX_BEATS = 8,
  parameter logic signed [ACC_W-1:0]   THRESH    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               pos_cnt,
  input  logic [4:0]               neg_cnt,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_act,
  output logic                     out_err
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [3:0]              MAX_CNT = 4'(MAX_BEATS);
  localparam logic signed [ACC_W-1:0] ZERO    = '0;
  localparam logic                    RST_ACT = (ZERO >= THRESH);

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [3:0]               beat_cnt;
  logic                     err_flag;
  logic                     accept, last_beat, out_take, over_beat;
  logic signed [5:0]        diff;
  logic signed [ACC_W-1:0]  diff_ext;

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  // A single-beat neuron closes on every beat, whatever in_last says.
  assign last_beat = in_last || (MAX_BEATS == 1);
  assign out_take  = out_valid && out_ready;
  assign over_beat = (beat_cnt == MAX_CNT);

  // Counts up to 31 are accepted unchecked; 6 signed bits hold -31..31.
  assign diff     = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
  assign diff_ext = ACC_W'(diff);

`ifdef ACC_SAT_EN
  logic [ACC_W:0] wide;
  always_comb begin
    wide    = {acc[ACC_W-1], acc} + {diff_ext[ACC_W-1], diff_ext};
    acc_nxt = wide[ACC_W-1:0];
    // Top two bits disagree only when the true sum left the ACC_W range.
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_nxt = acc + diff_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = last_beat ? OUT : ACC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      err_flag <= 1'b0;
      out_sum  <= '0;
      out_act  <= RST_ACT;
      out_err  <= 1'b0;
    end else if (out_take) begin
      acc      <= '0;
      beat_cnt <= '0;
      err_flag <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      // Counter parks at 15 so a runaway neuron cannot wrap it back to 0.
      if (beat_cnt != 4'hF) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (over_beat) begin
        err_flag <= 1'b1;
      end
      if (last_beat) begin
        out_sum <= acc_nxt;
        out_act <= (acc_nxt >= THRESH);
        out_err <= err_flag | over_beat;
      end
    end
  end

endmodule
